imu_spi_responder: RTL and testbench

//  SPI responder (slave) that emulates the accelerometer on the other end of the imu_multi SPI master.

---
 rtl/imu_spi_responder.sv | 205 ++++++++++++++++++++
 tb/tb_imu_spi_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imu_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : imu_spi_responder
//  Description : SPI mode-3 responder emulating an ST-style accelerometer
//                (WHO_AM_I, CTRL1-4, STATUS, OUT_X/Y/Z with per-burst snapshot)
//  Revision    : 1.0 - initial release
// ============================================================================
module imu_spi_responder #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
    parameter logic [7:0] CTRL1_RST    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS,
    input  logic        SPC,
    input  logic        SDI,
    output logic        SDO,
    input  logic [15:0] x_data,
    input  logic [15:0] y_data,
    input  logic [15:0] z_data,
    output logic [7:0]  ctrl1,
    output logic        txn_done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_cmd  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;

    localparam logic [7:0] c_status_val = 8'h0F;

    logic        r_cs_meta, r_cs_sync, r_cs_prev;
    logic        r_spc_meta, r_spc_sync, r_spc_prev;
    logic        r_sdi_meta, r_sdi_sync;

    logic [1:0]  r_state, w_state_nxt;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic        r_rw, r_ms;
    logic [5:0]  r_addr;
    logic [7:0]  r_tx_byte;
    logic [47:0] r_snapshot;
    logic [7:0]  r_ctrl [0:3];
    logic        r_sdo, r_data_seen, r_txn_done;

    logic        w_cs_rise, w_cs_fall, w_spc_rise, w_spc_fall, w_spc_ok;
    logic        w_cmd_rise, w_data_rise, w_data_fall;
    logic        w_byte_end, w_wr_hit;
    logic [7:0]  w_byte_in;
    logic [5:0]  w_next_addr, w_rd_addr;
    logic [47:0] w_rd_snap;
    logic [7:0]  w_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs_meta  <= 1'b1;
            r_cs_sync  <= 1'b1;
            r_cs_prev  <= 1'b1;
            r_spc_meta <= 1'b1;
            r_spc_sync <= 1'b1;
            r_spc_prev <= 1'b1;
            r_sdi_meta <= 1'b0;
            r_sdi_sync <= 1'b0;
        end else begin
            r_cs_meta  <= CS;
            r_cs_sync  <= r_cs_meta;
            r_cs_prev  <= r_cs_sync;
            r_spc_meta <= SPC;
            r_spc_sync <= r_spc_meta;
            r_spc_prev <= r_spc_sync;
            r_sdi_meta <= SDI;
            r_sdi_sync <= r_sdi_meta;
        end
    end

    // CS edges take priority; SPC edges only count while CS is low and stable
    assign w_cs_rise  = ~r_cs_prev & r_cs_sync;
    assign w_cs_fall  = r_cs_prev & ~r_cs_sync;
    assign w_spc_ok   = ~r_cs_sync & ~w_cs_fall;
    assign w_spc_rise = ~r_spc_prev & r_spc_sync & w_spc_ok;
    assign w_spc_fall = r_spc_prev & ~r_spc_sync & w_spc_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_cs_fall) w_state_nxt = c_st_cmd;
            c_st_cmd: begin
                if (w_cs_rise)                          w_state_nxt = c_st_idle;
                else if (w_cs_fall)                     w_state_nxt = c_st_cmd;
                else if (w_cmd_rise && r_bit_cnt == 3'd7) w_state_nxt = c_st_data;
            end
            c_st_data: begin
                if (w_cs_rise)      w_state_nxt = c_st_idle;
                else if (w_cs_fall) w_state_nxt = c_st_cmd;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_cmd_rise  = 1'b0;
        w_data_rise = 1'b0;
        w_data_fall = 1'b0;
        case (r_state)
            c_st_cmd:  w_cmd_rise = w_spc_rise;
            c_st_data: begin
                w_data_rise = w_spc_rise;
                w_data_fall = w_spc_fall & r_rw;
            end
            default: ;
        endcase
    end

    assign w_byte_in   = {r_shift, r_sdi_sync};
    assign w_byte_end  = (w_cmd_rise | w_data_rise) && (r_bit_cnt == 3'd7);
    assign w_next_addr = r_ms ? r_addr + 6'd1 : r_addr;
    assign w_wr_hit    = (r_addr[5:2] == 4'b1000);

    // The command byte reads with the live axis inputs, which become the snapshot
    assign w_rd_addr = (r_state == c_st_cmd) ? w_byte_in[5:0] : w_next_addr;
    assign w_rd_snap = (r_state == c_st_cmd) ? {z_data, y_data, x_data} : r_snapshot;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_rd_addr)
            6'h0F:                      w_rd_data = WHO_AM_I_VAL;
            6'h20, 6'h21, 6'h22, 6'h23: w_rd_data = r_ctrl[w_rd_addr[1:0]];
            6'h27:                      w_rd_data = c_status_val;
            6'h28:                      w_rd_data = w_rd_snap[7:0];
            6'h29:                      w_rd_data = w_rd_snap[15:8];
            6'h2A:                      w_rd_data = w_rd_snap[23:16];
            6'h2B:                      w_rd_data = w_rd_snap[31:24];
            6'h2C:                      w_rd_data = w_rd_snap[39:32];
            6'h2D:                      w_rd_data = w_rd_snap[47:40];
            default:                    w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_rw        <= 1'b0;
            r_ms        <= 1'b0;
            r_addr      <= 6'd0;
            r_tx_byte   <= 8'd0;
            r_snapshot  <= 48'd0;
            r_ctrl[0]   <= CTRL1_RST;
            r_ctrl[1]   <= 8'h00;
            r_ctrl[2]   <= 8'h00;
            r_ctrl[3]   <= 8'h00;
            r_sdo       <= 1'b1;
            r_data_seen <= 1'b0;
            r_txn_done  <= 1'b0;
        end else begin
            r_txn_done <= 1'b0;
            if (w_cs_rise) begin
                r_sdo       <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_txn_done  <= r_data_seen;
                r_data_seen <= 1'b0;
            end else if (w_cs_fall) begin
                r_sdo       <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_data_seen <= 1'b0;
            end else begin
                if (w_cmd_rise || w_data_rise) begin
                    r_shift   <= w_byte_in[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_end && w_cmd_rise) begin
                    r_rw   <= w_byte_in[7];
                    r_ms   <= w_byte_in[6];
                    r_addr <= w_byte_in[5:0];
                    if (w_byte_in[7]) begin
                        r_snapshot <= {z_data, y_data, x_data};
                        r_tx_byte  <= w_rd_data;
                    end
                end
                if (w_byte_end && w_data_rise) begin
                    r_data_seen <= 1'b1;
                    r_addr      <= w_next_addr;
                    if (r_rw)
                        r_tx_byte <= w_rd_data;
                    else if (w_wr_hit)
                        r_ctrl[r_addr[1:0]] <= w_byte_in;
                end
                if (w_data_fall) begin
                    r_sdo     <= r_tx_byte[7];
                    r_tx_byte <= {r_tx_byte[6:0], 1'b0};
                end
            end
        end
    end

    assign SDO      = r_sdo;
    assign ctrl1    = r_ctrl[0];
    assign txn_done = r_txn_done;

endmodule
`default_nettype wire

// File: tb/tb_imu_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imu_spi_responder
//  Description : Scoreboard bench for imu_spi_responder with a register-image
//                reference model and randomized SPI transactions
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imu_spi_responder;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        CS     = 1'b1;
    logic        SPC    = 1'b1;
    logic        SDI    = 1'b0;
    logic        SDO;
    logic [15:0] x_data = 16'h0000;
    logic [15:0] y_data = 16'h0000;
    logic [15:0] z_data = 16'h0000;
    logic [7:0]  ctrl1;
    logic        txn_done;

    always #5 clk = ~clk;

    imu_spi_responder dut (
        .clk      (clk),
        .reset    (reset),
        .CS       (CS),
        .SPC      (SPC),
        .SDI      (SDI),
        .SDO      (SDO),
        .x_data   (x_data),
        .y_data   (y_data),
        .z_data   (z_data),
        .ctrl1    (ctrl1),
        .txn_done (txn_done)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       exp_done_q[$];
    logic [7:0] ctrl_m [4];
    logic [15:0] sx, sy, sz;
    logic [7:0] wdat [8];
    int         x_change_after = -1;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a 64-byte register image built from the snapshot and ctrl state
    function automatic logic [7:0] img_read(input int a);
        logic [7:0] img [64];
        foreach (img[i]) img[i] = 8'h00;
        img[15] = 8'h33;
        for (int i = 0; i < 4; i++) img[32 + i] = ctrl_m[i];
        img[39] = 8'h0F;
        img[40] = sx[7:0];  img[41] = sx[15:8];
        img[42] = sy[7:0];  img[43] = sy[15:8];
        img[44] = sz[7:0];  img[45] = sz[15:8];
        return img[a];
    endfunction

    task automatic model_txn(input logic [7:0] cmd, input int nfull, input bit abort);
        int base = int'(cmd[5:0]);
        if (cmd[7]) begin
            sx = x_data; sy = y_data; sz = z_data;
        end
        exp_q.push_back(8'hFF);
        for (int k = 0; k < nfull; k++) begin
            int a = cmd[6] ? (base + k) % 64 : base;
            if (cmd[7]) exp_q.push_back(img_read(a));
            else begin
                exp_q.push_back(8'hFF);
                if (a >= 32 && a <= 35) ctrl_m[a - 32] = wdat[k];
            end
        end
        exp_done_q.push_back(!abort && nfull >= 1);
        if (abort) ctrl_m = '{default: 8'h00};
    endtask

    task automatic spi_bit(input logic b);
        @(negedge clk);
        SPC = 1'b0;
        SDI = b;
        repeat (5) @(negedge clk);
        SPC = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_txn(input logic [7:0] cmd, input int nfull, input int npart, input bit abort);
        logic [7:0] b;
        model_txn(cmd, nfull, abort);
        @(negedge clk);
        CS = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i]);
        for (int k = 0; k < nfull; k++) begin
            b = wdat[k];
            for (int i = 7; i >= 0; i--) spi_bit(b[i]);
            if (k == x_change_after) x_data = 16'hFFFF;
        end
        b = wdat[nfull];
        for (int i = 0; i < npart; i++) spi_bit(b[7 - i]);
        if (abort) begin
            reset = 1'b0;
            repeat (2) @(negedge clk);
            check("abort_sdo", 64'(SDO), 64'(1));
            check("abort_ctrl1", 64'(ctrl1), 64'(0));
            check("abort_txn_done", 64'(txn_done), 64'(0));
            CS = 1'b1;
            repeat (4) @(negedge clk);
            reset = 1'b1;
        end else begin
            repeat (6) @(negedge clk);
            CS = 1'b1;
        end
        repeat (14) @(negedge clk);
        check("ctrl1", 64'(ctrl1), 64'(ctrl_m[0]));
    endtask

    // SDO monitor: assemble each 8-bit frame as the master sees it and score it
    int         mbits = 0;
    logic [7:0] msh   = 8'h00;
    always @(posedge SPC or posedge CS) begin
        if (CS) mbits = 0;
        else if (mon_en) begin
            msh = {msh[6:0], SDO};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sdo_byte: got %0h, expected no byte", msh);
                end else begin
                    check("sdo_byte", 64'(msh), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    always @(posedge CS) begin : done_mon
        int   seen;
        logic e;
        if (mon_en) begin
            seen = 0;
            repeat (10) @(negedge clk) if (txn_done) seen++;
            if (exp_done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL txn_done: got %0d pulses, expected no transaction", seen);
            end else begin
                e = exp_done_q.pop_front();
                check("txn_done_pulses", 64'(seen), 64'(e));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] alist [14] = '{6'h0F, 6'h20, 6'h21, 6'h22, 6'h23, 6'h27, 6'h28,
                               6'h29, 6'h2A, 6'h2C, 6'h2D, 6'h3E, 6'h3F, 6'h05};

    initial begin
        logic [7:0] cmd;
        int nfull, npart;
        ctrl_m = '{default: 8'h00};
        foreach (wdat[i]) wdat[i] = 8'h00;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_sdo", 64'(SDO), 64'(1));
        check("reset_ctrl1", 64'(ctrl1), 64'(0));
        check("reset_txn_done", 64'(txn_done), 64'(0));
        reset = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        do_txn(8'h8F, 1, 0, 1'b0);

        x_data = 16'h1234; y_data = 16'hABCD; z_data = 16'h8001;
        x_change_after = 0;
        do_txn(8'hE8, 6, 0, 1'b0);
        x_change_after = -1;

        wdat[0] = 8'h57;
        do_txn(8'h20, 1, 0, 1'b0);
        do_txn(8'hA0, 1, 0, 1'b0);

        // Partial write byte must be discarded
        wdat[0] = 8'hFF;
        do_txn(8'h20, 0, 4, 1'b0);
        do_txn(8'hA0, 1, 0, 1'b0);

        do_txn(8'hFF, 2, 0, 1'b0);
        do_txn(8'hCF, 2, 0, 1'b0);

        x_data = 16'h1234;
        do_txn(8'hE8, 2, 3, 1'b1);
        do_txn(8'h8F, 1, 0, 1'b0);

        for (int r = 0; r < 24; r++) begin
            x_data = 16'($urandom);
            y_data = 16'($urandom);
            z_data = 16'($urandom);
            cmd[7] = 1'($urandom_range(0, 1));
            cmd[6] = 1'($urandom_range(0, 1));
            cmd[5:0] = ($urandom_range(0, 4) == 0) ? 6'($urandom) : alist[$urandom_range(0, 13)];
            nfull = $urandom_range(0, 4);
            npart = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            foreach (wdat[i]) wdat[i] = 8'($urandom);
            do_txn(cmd, nfull, npart, 1'b0);
        end

        repeat (20) @(negedge clk);
        check("sdo_queue_left", 64'(exp_q.size()), 64'(0));
        check("done_queue_left", 64'(exp_done_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
